pcs_eth_10g_mac_rx_stat_collector: RTL

//  Consumes the 10G MAC RX statistics stream (40b status word + 7b mapped error vector)
//  and accumulates 8 per-port RX counters. The counter bank is shared between the

---
 rtl/pcs_eth_10g_rx_stat_pkg.sv | 36 +++
 rtl/pcs_eth_10g_rx_stat_cnt.sv | 33 +++
 rtl/pcs_eth_10g_mac_rx_stat_collector.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pcs_eth_10g_rx_stat_pkg.sv
// Shared constants and types for the 10G MAC RX statistics collector.
// Covers counter indices, error-vector bit positions, CSR addresses and sweep FSM states.
package pcs_eth_10g_rx_stat_pkg;

    localparam int NUM_CNT = 8;

    localparam int CNT_FRAMES_OK   = 0;
    localparam int CNT_FRAMES_ERR  = 1;
    localparam int CNT_UNDERSIZE   = 2;
    localparam int CNT_OVERSIZE    = 3;
    localparam int CNT_PAYLOAD_LEN = 4;
    localparam int CNT_CRC         = 5;
    localparam int CNT_PHY         = 6;
    localparam int CNT_OCTETS_OK   = 7;

    localparam int ERR_UNDERSIZE   = 0;
    localparam int ERR_OVERSIZE    = 1;
    localparam int ERR_PAYLOAD_LEN = 2;
    localparam int ERR_CRC         = 3;
    localparam int ERR_PHY         = 6;

    localparam logic [4:0] CSR_ADDR_CTRL   = 5'd16;
    localparam logic [4:0] CSR_ADDR_STATUS = 5'd17;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

    // Bits [5:4] of the mapped error vector carry no counted error.
    function automatic logic frame_has_err(input logic [6:0] err);
        return err[ERR_PHY] | err[ERR_CRC] | err[ERR_PAYLOAD_LEN] |
               err[ERR_OVERSIZE] | err[ERR_UNDERSIZE];
    endfunction

endpackage

// File: rtl/pcs_eth_10g_rx_stat_cnt.sv
// One wrapping statistics counter with a clear that never loses a same-cycle increment.
module pcs_eth_10g_rx_stat_cnt #(
    parameter int CNT_W = 36
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_en,
    input  logic [CNT_W-1:0] inc_amt,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] base;

    // A clear replaces the old value; an increment on the same edge survives it.
    always_comb begin
        base     = clr ? '0 : cnt_reg;
        cnt_next = inc_en ? base + inc_amt : base;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/pcs_eth_10g_mac_rx_stat_collector.sv
// Accumulates 8 RX statistics counters from the MAC status stream and exposes them
// over an Avalon-MM CSR slave with split low/high reads, clear-on-read and clear-all sweep.
module pcs_eth_10g_mac_rx_stat_collector
    import pcs_eth_10g_rx_stat_pkg::*;
#(
    parameter int CNT_W     = 36,
    parameter bit CLR_ON_RD = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [39:0] in_data,
    input  logic [6:0]  in_error,
    input  logic [4:0]  csr_address,
    input  logic        csr_read,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    output logic        csr_readdatavalid,
    output logic        csr_waitrequest
);

    logic             valid_reg;
    logic [15:0]      len_reg;
    logic [6:0]       err_reg;

    logic             frame_err;
    logic             frame_ok;
    logic [NUM_CNT-1:0] inc_en;
    logic [CNT_W-1:0] inc_amt [NUM_CNT];
    logic [NUM_CNT-1:0] clr;
    logic [CNT_W-1:0] cnt [NUM_CNT];

    logic             rd_accept;
    logic             wr_accept;
    logic             low_rd;
    logic [2:0]       rd_idx;
    logic             ctrl_wr;
    logic             clr_on_rd_reg;
    logic [CNT_W-33:0] shadow_reg;
    logic [31:0]      shadow_ext;
    logic [31:0]      rd_mux;

    sweep_state_t     state_reg;
    sweep_state_t     state_next;
    logic [2:0]       ptr_reg;
    logic             sweep_busy;
    logic [NUM_CNT-1:0] sweep_clr;

    logic             unused_bits;
    assign unused_bits = ^{in_data[39:16], err_reg[5:4], csr_writedata[31:2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= 1'b0;
            len_reg   <= '0;
            err_reg   <= '0;
        end else begin
            valid_reg <= in_valid;
            len_reg   <= in_data[15:0];
            err_reg   <= in_error;
        end
    end

    assign frame_err = frame_has_err(err_reg);
    assign frame_ok  = valid_reg & ~frame_err;

    assign inc_en[CNT_FRAMES_OK]   = frame_ok;
    assign inc_en[CNT_FRAMES_ERR]  = valid_reg & frame_err;
    assign inc_en[CNT_UNDERSIZE]   = valid_reg & err_reg[ERR_UNDERSIZE];
    assign inc_en[CNT_OVERSIZE]    = valid_reg & err_reg[ERR_OVERSIZE];
    assign inc_en[CNT_PAYLOAD_LEN] = valid_reg & err_reg[ERR_PAYLOAD_LEN];
    assign inc_en[CNT_CRC]         = valid_reg & err_reg[ERR_CRC];
    assign inc_en[CNT_PHY]         = valid_reg & err_reg[ERR_PHY];
    assign inc_en[CNT_OCTETS_OK]   = frame_ok;

    assign rd_accept = csr_read & ~csr_waitrequest;
    assign wr_accept = csr_write & ~csr_read & ~csr_waitrequest;
    assign rd_idx    = csr_address[3:1];
    assign low_rd    = rd_accept & ~csr_address[4] & ~csr_address[0];
    assign ctrl_wr   = wr_accept & (csr_address == CSR_ADDR_CTRL);

    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
        if (gi == CNT_OCTETS_OK) begin : g_amt_len
            assign inc_amt[gi] = {{(CNT_W-16){1'b0}}, len_reg};
        end else begin : g_amt_one
            assign inc_amt[gi] = {{(CNT_W-1){1'b0}}, 1'b1};
        end

        assign clr[gi] = sweep_clr[gi] | (low_rd & clr_on_rd_reg & (rd_idx == 3'(gi)));

        pcs_eth_10g_rx_stat_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .inc_en  (inc_en[gi]),
            .inc_amt (inc_amt[gi]),
            .clr     (clr[gi]),
            .cnt     (cnt[gi])
        );
    end

    always_comb begin
        shadow_ext = '0;
        shadow_ext[CNT_W-33:0] = shadow_reg;
    end

    always_comb begin
        rd_mux = '0;
        if (!csr_address[4]) begin
            rd_mux = csr_address[0] ? shadow_ext : cnt[rd_idx][31:0];
        end else if (csr_address == CSR_ADDR_CTRL) begin
            rd_mux = {30'd0, clr_on_rd_reg, 1'b0};
        end else if (csr_address == CSR_ADDR_STATUS) begin
            rd_mux = {31'd0, sweep_busy};
        end
    end

    // The shadow captures the upper bits of whichever counter was read low last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csr_readdata      <= '0;
            csr_readdatavalid <= 1'b0;
            shadow_reg        <= '0;
            clr_on_rd_reg     <= CLR_ON_RD;
        end else begin
            csr_readdatavalid <= rd_accept;
            if (rd_accept) begin
                csr_readdata <= rd_mux;
            end
            if (low_rd) begin
                shadow_reg <= cnt[rd_idx][CNT_W-1:32];
            end
            if (ctrl_wr) begin
                clr_on_rd_reg <= csr_writedata[1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= (state_reg == SWEEP) ? ptr_reg + 3'd1 : 3'd0;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ctrl_wr && csr_writedata[0]) state_next = SWEEP;
            SWEEP:   if (ptr_reg == 3'd7) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sweep_busy = (state_reg == SWEEP);
        sweep_clr  = '0;
        if (sweep_busy) begin
            sweep_clr[ptr_reg] = 1'b1;
        end
    end

    assign csr_waitrequest = sweep_busy;

endmodule
